// File: rtl/apb_master_bridge.sv
// Valid/ready command to single-transfer APB master bridge with a PREADY blanking
// window and an ACCESS timeout; one outstanding transfer, all outputs registered.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MIN_WAIT       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] MinCnt  = CntW'(MIN_WAIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                r_state,     w_state_nxt;
  logic [CntW-1:0]       r_wait_cnt,  w_wait_cnt_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_psel,      w_psel_nxt;
  logic                  r_penable,   w_penable_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr,     w_paddr_nxt;
  logic                  r_pwrite,    w_pwrite_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata,    w_pwdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;

  logic w_wait_ok;
  logic w_done;
  logic w_timeout;

  // PREADY is blanked for the first MIN_WAIT ACCESS cycles to reject a stale ready.
  assign w_wait_ok = (r_wait_cnt >= MinCnt);
  assign w_done    = PREADY & w_wait_ok;
  assign w_timeout = (r_wait_cnt == LastCnt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_wait_cnt  <= '0;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_cmd_ready_nxt = r_cmd_ready;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;

    unique case (r_state)
      StIdle: begin
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_paddr_nxt     = cmd_addr;
          w_pwrite_nxt    = cmd_write;
          w_pwdata_nxt    = cmd_wdata;
          w_cmd_ready_nxt = 1'b0;
          w_psel_nxt      = 1'b1;
          w_state_nxt     = StSetup;
        end
      end
      StSetup: begin
        w_penable_nxt  = 1'b1;
        w_wait_cnt_nxt = '0;
        w_state_nxt    = StAccess;
      end
      StAccess: begin
        // Completion wins over timeout when both land in the last cycle.
        if (w_done) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
          w_rsp_err_nxt   = 1'b0;
          w_state_nxt     = StResp;
        end else if (w_timeout) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = StResp;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      StResp: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized
// transfers checked against a transaction-level model of completion/timeout.
module tb_apb_master_bridge;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int MW  = 1;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;

  apb_master_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .MIN_WAIT      (MW),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration: PREADY from ACCESS index cfg_rdy_from on (-1 = never),
  // or stuck high everywhere when cfg_stale; cfg_skew adds the ACCESS index to PRDATA.
  int cfg_rdy_from = -1;
  bit cfg_stale    = 1'b0;
  bit cfg_skew     = 1'b0;
  int acc_cnt      = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  logic          nxt_write;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_wdata;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 16'h5A5A, a};
  endfunction

  always @(negedge clk) begin
    if (PSEL && PENABLE) begin
      PREADY = cfg_stale || (cfg_rdy_from >= 0 && acc_cnt >= cfg_rdy_from);
      PRDATA = slave_word(PADDR) + (cfg_skew ? DW'(acc_cnt) : '0);
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY  = cfg_stale;
      PRDATA  = $urandom;
    end
  end

  // Runs one transfer from a negedge and returns at a negedge after the response handshake.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int rdy_from, input bit stale, input bit skew,
                         input int rsp_dly, input bit hold_next, input bit expect_imm);
    int k, i, n_acc, lat, en_cnt, waitc;
    bit to, seq_ok, stab_ok;
    logic [DW-1:0] exp_rd;
    k  = stale ? 0 : rdy_from;
    i  = 0;
    to = 1'b0;
    if (k < 0) to = 1'b1;
    else begin
      i = (k > MW) ? k : MW;
      if (i > TO - 1) to = 1'b1;
    end
    n_acc  = to ? TO : i + 1;
    exp_rd = (wr || to) ? '0 : slave_word(addr) + (skew ? DW'(i) : '0);
    cfg_rdy_from = rdy_from;
    cfg_stale    = stale;
    cfg_skew     = skew;

    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    waitc = 0;
    while (!cmd_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) begin
      check_eq("accept_timeout", 64'(waitc), 64'(0));
      cmd_valid = 1'b0;
      return;
    end
    if (expect_imm) check_eq("accept_immediate", 64'(waitc), 64'(0));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat    = 1;
    en_cnt = 0;
    seq_ok = PSEL && !PENABLE && !rsp_valid && PADDR == addr && PWRITE == wr && PWDATA == wd;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seq_ok &= !PSEL && !PENABLE;
      else if (PENABLE) begin
        en_cnt++;
        seq_ok &= PSEL && PADDR == addr && PWRITE == wr && PWDATA == wd;
      end else seq_ok = 1'b0;
    end
    check_eq("rsp_latency", 64'(lat), 64'(n_acc + 2));
    check_eq("penable_cycles", 64'(en_cnt), 64'(n_acc));
    check_eq("apb_sequence", 64'(seq_ok), 64'(1));
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    check_eq("rsp_err", 64'(rsp_err), 64'(to));
    check_eq("cmd_ready_in_resp", 64'(cmd_ready), 64'(0));

    stab_ok = 1'b1;
    if (hold_next) begin
      cmd_write = nxt_write;
      cmd_addr  = nxt_addr;
      cmd_wdata = nxt_wdata;
      cmd_valid = 1'b1;
    end
    for (int d = 0; d < rsp_dly; d++) begin
      @(negedge clk);
      stab_ok &= rsp_valid && rsp_rdata == exp_rd && rsp_err == to && !cmd_ready && !PSEL;
    end
    if (rsp_dly > 0) check_eq("resp_hold_stable", 64'(stab_ok), 64'(1));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_hs", 64'(rsp_valid), 64'(0));
    check_eq("cmd_ready_after_hs", 64'(cmd_ready), 64'(1));
    if (wr && !to) mem[addr] = wd;
  endtask

  initial begin
    int waitc;
    bit saw_rsp;
    bit saw_psel;

    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_psel_penable", 64'({PSEL, PENABLE}), 64'(0));
    check_eq("rst_paddr_pwrite", 64'({PADDR, PWRITE}), 64'(0));
    check_eq("rst_pwdata", 64'(PWDATA), 64'(0));
    check_eq("rst_rsp_data_err", 64'({rsp_rdata, rsp_err}), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    check_eq("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

    // Write then read with PREADY from the 2nd ACCESS cycle.
    do_xfer(1'b1, 16'h0040, 32'hDEADBEEF, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 16'h0040, 32'h0, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // Stale PREADY: must complete in ACCESS cycle 2 with that cycle's PRDATA.
    do_xfer(1'b0, 16'h0080, 32'h1234, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    cfg_stale = 1'b0;
    // Timeout, then PREADY in the final cycle, then one cycle too late.
    do_xfer(1'b0, 16'h00C0, 32'h0, -1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    do_xfer(1'b0, 16'h00C4, 32'h0, TO - 1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 16'h00C8, 32'hCAFEF00D, TO, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    // Response backpressure with the next command already waiting.
    nxt_write = 1'b1;
    nxt_addr  = 16'h0044;
    nxt_wdata = 32'hA5A5_0044;
    do_xfer(1'b0, 16'h0040, 32'h0, 2, 1'b0, 1'b1, 5, 1'b1, 1'b0);
    do_xfer(nxt_write, nxt_addr, nxt_wdata, 1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    do_xfer(1'b0, 16'h0044, 32'h0, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Reset during ACCESS cycle 2 of a read at 0x0100.
    cfg_rdy_from = -1;
    cfg_stale    = 1'b0;
    cmd_write    = 1'b0;
    cmd_addr     = 16'h0100;
    cmd_wdata    = $urandom;
    cmd_valid    = 1'b1;
    waitc = 0;
    while (!cmd_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("rstmid_accept", 64'(waitc < 50), 64'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rstmid_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    rstn = 1'b0;
    #1;
    check_eq("rstmid_outputs", 64'({PSEL, PENABLE, rsp_valid, cmd_ready}), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rstmid_cmd_ready", 64'(cmd_ready), 64'(1));
    saw_rsp  = 1'b0;
    saw_psel = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_rsp  |= rsp_valid;
      saw_psel |= PSEL;
    end
    check_eq("rstmid_no_rsp", 64'({saw_rsp, saw_psel}), 64'(0));

    // Randomized transfers against the transaction model.
    for (int n = 0; n < 40; n++) begin
      bit            wr;
      logic [AW-1:0] addr;
      int            rf;
      bit            st;
      wr   = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 7)) << 2;
      rf   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO + 1));
      st   = ($urandom_range(0, 5) == 0);
      do_xfer(wr, addr, $urandom, rf, st, 1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      cfg_stale = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
